// File: rtl/picosoc_bus_pkg.sv
// picosoc_bus_pkg: shared widths and FSM encoding for the picorv32 native-bus interconnect.
// Optional build macro used by the interconnect: PICOSOC_BUS_TIMEOUT_EN.
package picosoc_bus_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;
  localparam int TMO_W  = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    BUS_IDLE   = ST_IDLE,
    BUS_ACTIVE = ST_ACTIVE,
    BUS_RESP   = ST_RESP
  } bus_state_e;

endpackage

// File: rtl/picosoc_bus_decode.sv
// picosoc_bus_decode: combinational address-window decoder.
// Overlapping windows resolve to the lowest slave index; kept standalone so other
// master ports can reuse the same decode.
module picosoc_bus_decode
  import picosoc_bus_pkg::*;
#(
  parameter int                           NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*WORD_W-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0000_0000}},
  parameter logic [NUM_SLAVES*WORD_W-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_FF00}}
) (
  input  logic [WORD_W-1:0]     i_addr,
  output logic                  o_hit,
  output logic [NUM_SLAVES-1:0] o_sel
);

  // Priority decode: the first window that matches claims the access.
  always_comb begin
    o_hit = 1'b0;
    o_sel = {NUM_SLAVES{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!o_hit && ((i_addr & SLAVE_MASK[WORD_W*i +: WORD_W]) ==
                     (SLAVE_BASE[WORD_W*i +: WORD_W] & SLAVE_MASK[WORD_W*i +: WORD_W]))) begin
        o_hit    = 1'b1;
        o_sel[i] = 1'b1;
      end else begin
        o_sel[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/picosoc_bus_ic.sv
// picosoc_bus_ic: N-slave interconnect for the picorv32 native memory bus.
// Registers the request toward one decoded slave and returns a single registered
// m_ready/m_rdata. Decode misses (and, with PICOSOC_BUS_TIMEOUT_EN defined, hung
// slaves) complete with DEFAULT_RDATA and an err_pulse instead of stalling the CPU.
module picosoc_bus_ic
  import picosoc_bus_pkg::*;
#(
  parameter int                           NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*WORD_W-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0000_0000}},
  parameter logic [NUM_SLAVES*WORD_W-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_FF00}},
  parameter logic [WORD_W-1:0]            DEFAULT_RDATA  = 32'hDEAD_BEEF,
  parameter int                           TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_valid,
  input  logic                         m_instr,
  input  logic [WORD_W-1:0]            m_addr,
  input  logic [WORD_W-1:0]            m_wdata,
  input  logic [STRB_W-1:0]            m_wstrb,
  output logic                         m_ready,
  output logic [WORD_W-1:0]            m_rdata,
  output logic [NUM_SLAVES-1:0]        s_valid,
  output logic                         s_instr,
  output logic [WORD_W-1:0]            s_addr,
  output logic [WORD_W-1:0]            s_wdata,
  output logic [STRB_W-1:0]            s_wstrb,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*WORD_W-1:0] s_rdata,
  output logic                         err_pulse,
  output logic [WORD_W-1:0]            err_addr
);

  // Reject configurations the counter and select vector cannot represent.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
    $error("picosoc_bus_ic: NUM_SLAVES out of range 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("picosoc_bus_ic: TIMEOUT_CYCLES out of range 1..65535");
  end

  bus_state_e              r_state;
  logic [NUM_SLAVES-1:0]   r_sel;
  logic                    r_m_ready;
  logic [WORD_W-1:0]       r_m_rdata;
  logic [NUM_SLAVES-1:0]   r_s_valid;
  logic                    r_s_instr;
  logic [WORD_W-1:0]       r_s_addr;
  logic [WORD_W-1:0]       r_s_wdata;
  logic [STRB_W-1:0]       r_s_wstrb;
  logic                    r_err_pulse;
  logic [WORD_W-1:0]       r_err_addr;

  logic                    w_hit;
  logic [NUM_SLAVES-1:0]   w_sel;
  logic                    w_sel_ready;
  logic [WORD_W-1:0]       w_sel_rdata;
  logic                    w_tmo_expire;

  picosoc_bus_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .i_addr (m_addr),
    .o_hit  (w_hit),
    .o_sel  (w_sel)
  );

  // Steer only the latched slave's ready/rdata back toward the CPU.
  always_comb begin
    w_sel_ready = |(s_ready & r_sel);
    w_sel_rdata = {WORD_W{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_sel_rdata = w_sel_rdata | (s_rdata[WORD_W*i +: WORD_W] & {WORD_W{r_sel[i]}});
    end
  end

`ifdef PICOSOC_BUS_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Count ACTIVE cycles left unanswered; cleared in IDLE so each access starts at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= {TMO_W{1'b0}};
    end else if (r_state == BUS_IDLE) begin
      r_tmo_cnt <= {TMO_W{1'b0}};
    end else if (r_state == BUS_ACTIVE && !w_sel_ready) begin
      r_tmo_cnt <= r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end

  // Expiry is the last unanswered ACTIVE cycle; a same-cycle s_ready still wins in the FSM.
  assign w_tmo_expire = (r_tmo_cnt == TMO_LAST);
`else
  assign w_tmo_expire = 1'b0;
`endif

  // Request FSM; every CPU- and slave-facing output is a register written here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= BUS_IDLE;
      r_sel       <= {NUM_SLAVES{1'b0}};
      r_m_ready   <= 1'b0;
      r_m_rdata   <= {WORD_W{1'b0}};
      r_s_valid   <= {NUM_SLAVES{1'b0}};
      r_s_instr   <= 1'b0;
      r_s_addr    <= {WORD_W{1'b0}};
      r_s_wdata   <= {WORD_W{1'b0}};
      r_s_wstrb   <= {STRB_W{1'b0}};
      r_err_pulse <= 1'b0;
      r_err_addr  <= {WORD_W{1'b0}};
    end else begin
      r_m_ready   <= 1'b0;
      r_err_pulse <= 1'b0;
      case (r_state)
        BUS_IDLE: begin
          if (m_valid && w_hit) begin
            r_sel     <= w_sel;
            r_s_valid <= w_sel;
            r_s_instr <= m_instr;
            r_s_addr  <= m_addr;
            r_s_wdata <= m_wdata;
            r_s_wstrb <= m_wstrb;
            r_state   <= BUS_ACTIVE;
          end else if (m_valid) begin
            // Unmapped: writes are dropped, reads see the default pattern.
            r_m_rdata   <= DEFAULT_RDATA;
            r_err_pulse <= 1'b1;
            r_err_addr  <= m_addr;
            r_m_ready   <= 1'b1;
            r_state     <= BUS_RESP;
          end else begin
            r_state <= BUS_IDLE;
          end
        end
        BUS_ACTIVE: begin
          if (w_sel_ready) begin
            r_m_rdata <= w_sel_rdata;
            r_s_valid <= {NUM_SLAVES{1'b0}};
            r_m_ready <= 1'b1;
            r_state   <= BUS_RESP;
          end else if (w_tmo_expire) begin
            r_m_rdata   <= DEFAULT_RDATA;
            r_s_valid   <= {NUM_SLAVES{1'b0}};
            r_err_pulse <= 1'b1;
            r_err_addr  <= r_s_addr;
            r_m_ready   <= 1'b1;
            r_state     <= BUS_RESP;
          end else begin
            r_state <= BUS_ACTIVE;
          end
        end
        BUS_RESP: begin
          // m_ready is high for this one cycle; m_valid is deliberately not sampled here.
          r_state <= BUS_IDLE;
        end
        default: begin
          r_s_valid <= {NUM_SLAVES{1'b0}};
          r_state   <= BUS_IDLE;
        end
      endcase
    end
  end

  assign m_ready   = r_m_ready;
  assign m_rdata   = r_m_rdata;
  assign s_valid   = r_s_valid;
  assign s_instr   = r_s_instr;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign s_wstrb   = r_s_wstrb;
  assign err_pulse = r_err_pulse;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_picosoc_bus_ic.sv
// tb_picosoc_bus_ic: directed plus randomized checks of picosoc_bus_ic against a
// behavioural model of the address map and handshake timing.
// Timing model: after m_valid is presented, a hit whose slave answers after W
// unanswered ACTIVE cycles shows m_ready (and m_rdata) just after edge W+2; a miss
// shows m_ready and err_pulse just after edge 1. With PICOSOC_BUS_TIMEOUT_EN a hung
// slave is aborted and m_ready/err_pulse show just after edge TIMEOUT_CYCLES+1.
module tb_picosoc_bus_ic;

  localparam int NS  = 4;
  localparam int TMO = 8;
  localparam logic [NS*32-1:0] BASE = {32'h0300_0000, 32'h0000_0000, 32'h0200_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00};
  localparam logic [31:0]      DEF  = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic              m_valid;
  logic              m_instr;
  logic [31:0]       m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_ready;
  logic [31:0]       m_rdata;
  logic [NS-1:0]     s_valid;
  logic              s_instr;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [NS-1:0]     s_ready;
  logic [NS*32-1:0]  s_rdata;
  logic              err_pulse;
  logic [31:0]       err_addr;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          wait_cfg [NS];
  logic        hang     [NS];
  int          cnt      [NS];
  logic        noise_en;
  logic [31:0] last_err;

  picosoc_bus_ic #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (BASE),
    .SLAVE_MASK     (MASK),
    .DEFAULT_RDATA  (DEF),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_valid   (m_valid),
    .m_instr   (m_instr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .s_valid   (s_valid),
    .s_instr   (s_instr),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .err_pulse (err_pulse),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  // Slave models: answer after a programmed number of wait cycles; idle slaves may toggle noise.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_valid[i]) begin
        s_ready[i] = !hang[i] && (cnt[i] == wait_cfg[i]);
        cnt[i]     = cnt[i] + 1;
      end else begin
        cnt[i]     = 0;
        s_ready[i] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Address map model: first window whose masked base matches; -1 when none does.
  function automatic int ref_target(input logic [31:0] a);
    logic [31:0] b;
    logic [31:0] m;
    for (int i = 0; i < NS; i++) begin
      b = BASE[32*i +: 32];
      m = MASK[32*i +: 32];
      if ((a & m) == (b & m)) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete CPU access with timing, data and error expectations from the model.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                         input logic instr, input int w, input logic hang_t, input logic [31:0] rd_sel);
    int          tgt;
    int          exp_edge;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [NS-1:0] exp_sv;
    int          rdy_edge;
    int          rdy_cnt;
    int          err_cnt;

    tgt = ref_target(addr);
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i]      = w;
      hang[i]          = hang_t;
      s_rdata[32*i +: 32] = $urandom();
    end
    exp_sv = '0;
    if (tgt < 0) begin
      exp_edge = 1;
      exp_err  = 1'b1;
      exp_rd   = DEF;
    end else begin
      exp_sv[tgt]           = 1'b1;
      s_rdata[32*tgt +: 32] = rd_sel;
      if (hang_t || w >= TMO) begin
        exp_edge = TMO + 1;
        exp_err  = 1'b1;
        exp_rd   = DEF;
      end else begin
        exp_edge = w + 2;
        exp_err  = 1'b0;
        exp_rd   = rd_sel;
      end
    end
    if (exp_err) last_err = addr;

    m_addr  = addr;
    m_wdata = wdata;
    m_wstrb = strb;
    m_instr = instr;
    m_valid = 1'b1;
    rdy_edge = 0;
    rdy_cnt  = 0;
    err_cnt  = 0;
    for (int k = 1; k <= exp_edge + 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        check("s_valid_accept", 32'(s_valid), 32'(exp_sv));
        if (tgt >= 0) begin
          check("s_addr", s_addr, addr);
          check("s_wdata", s_wdata, wdata);
          check("s_wstrb", 32'(s_wstrb), 32'(strb));
          check("s_instr", 32'(s_instr), 32'(instr));
        end
        // Accepted request: later bus changes must not reach the slave side.
        m_addr  = $urandom();
        m_wdata = $urandom();
      end
      if (k == exp_edge - 1 && k > 1) check("s_valid_held", 32'(s_valid), 32'(exp_sv));
      if (k == exp_edge) check("s_valid_done", 32'(s_valid), 32'h0);
      if (m_ready) begin
        rdy_cnt++;
        if (rdy_edge == 0) begin
          rdy_edge = k;
          check("m_rdata", m_rdata, exp_rd);
          m_valid = 1'b0;
        end
      end
      if (err_pulse) begin
        err_cnt++;
        check("err_addr_on_err", err_addr, addr);
      end
    end
    m_valid = 1'b0;
    check("ready_edge", 32'(rdy_edge), 32'(exp_edge));
    check("ready_count", 32'(rdy_cnt), 32'd1);
    check("err_count", 32'(err_cnt), 32'(exp_err));
    check("err_addr_hold", err_addr, last_err);
    if (tgt >= 0 && !exp_err) check("s_addr_stable", s_addr, addr);
  endtask

  initial begin
    int          tsel;
    int          rsv_ready;
    logic [31:0] a;

    reset    = 1'b1;
    m_valid  = 1'b0;
    m_instr  = 1'b0;
    m_addr   = 32'h0;
    m_wdata  = 32'h0;
    m_wstrb  = 4'h0;
    s_rdata  = '0;
    noise_en = 1'b0;
    last_err = 32'h0;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0;
      hang[i]     = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_m_ready", 32'(m_ready), 32'h0);
    check("rst_m_rdata", m_rdata, 32'h0);
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_s_instr", 32'(s_instr), 32'h0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_s_wdata", s_wdata, 32'h0);
    check("rst_s_wstrb", 32'(s_wstrb), 32'h0);
    check("rst_err_pulse", 32'(err_pulse), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed: zero-wait read, slow write, overlap priority, unmapped read, instruction fetch.
    run_txn(32'h0200_0004, 4'b0000, 32'h0,         1'b0, 0, 1'b0, 32'h1234_5678);
    run_txn(32'h0200_0008, 4'b0001, 32'h0000_00A5, 1'b0, 5, 1'b0, 32'h0BAD_0001);
    run_txn(32'h0000_0010, 4'b0000, 32'h0,         1'b0, 1, 1'b0, 32'hC0DE_0010);
    run_txn(32'h3000_0000, 4'b0000, 32'h0,         1'b0, 0, 1'b0, 32'h0);
    run_txn(32'h0000_0200, 4'b1111, 32'h5555_AAAA, 1'b0, 2, 1'b0, 32'h2222_0200);
    run_txn(32'h0300_0ABC, 4'b0000, 32'h0,         1'b1, 3, 1'b0, 32'h3333_3333);

`ifdef PICOSOC_BUS_TIMEOUT_EN
    // Hung slave aborts; then a slave answering on the expiry cycle completes normally.
    run_txn(32'h0200_0040, 4'b0000, 32'h0, 1'b0, 0,       1'b1, 32'h4444_4444);
    run_txn(32'h0200_0044, 4'b0000, 32'h0, 1'b0, TMO - 1, 1'b0, 32'h5A5A_5A5A);
`endif

    // Reset while ACTIVE: slave request withdrawn, no completion or error follows.
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 1000;
      hang[i]     = 1'b0;
    end
    m_addr  = 32'h0200_0010;
    m_wstrb = 4'b0000;
    m_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_accept", 32'(s_valid), 32'h2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_s_valid", 32'(s_valid), 32'h0);
    check("rst_mid_m_ready", 32'(m_ready), 32'h0);
    check("rst_mid_err", 32'(err_pulse), 32'h0);
    reset     = 1'b0;
    m_valid   = 1'b0;
    rsv_ready = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (m_ready || err_pulse || s_valid != '0) rsv_ready++;
    end
    check("rst_mid_quiet", 32'(rsv_ready), 32'h0);
    last_err = 32'h0;
    run_txn(32'h0200_0020, 4'b0000, 32'h0, 1'b0, 0, 1'b0, 32'h7777_0020);

    // Randomized accesses with noise on the non-selected ready lines.
    noise_en = 1'b1;
    for (int n = 0; n < 24; n++) begin
      tsel = $urandom_range(0, 4);
      case (tsel)
        0:       a = {24'h00_0000, 8'($urandom())};
        1:       a = {24'h02_0000, 8'($urandom())};
        2:       a = {16'h0000, 16'($urandom())};
        3:       a = {20'h0300_0, 12'($urandom())};
        default: a = {4'h3, 28'($urandom())};
      endcase
      run_txn(a, 4'($urandom()), $urandom(), 1'($urandom()), $urandom_range(0, 5), 1'b0, $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
